seven_seg_scan_controller: RTL and testbench

SEVEN_SEG_SCAN_CONTROLLER -- requirements
Module: seven_seg_scan_controller

---
 rtl/seven_seg_scan_controller.sv | 179 +++++++++++++++++
 tb/tb_seven_seg_scan_controller.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_controller.sv
// Multiplexed seven-segment scan controller: BLANK/DWELL digit scan, frame-aligned load.
// Ports: CLK, RESET (async high), VALUE_IN/LOAD/READY, DISPLAY, ANODE, FRAME_DONE.
// Option: define LEADING_ZERO_BLANK_EN to darken leading-zero digits (digit 0 always lit).
module seven_seg_scan_controller #(
  parameter int DIGITS       = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [4*DIGITS-1:0]   VALUE_IN,
  input  logic                  LOAD,
  output logic                  READY,
  output logic [6:0]            DISPLAY,
  output logic [DIGITS-1:0]     ANODE,
  output logic                  FRAME_DONE
);

  localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ?
                        DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] DW_LAST  = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BL_LAST  =
    CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic {
    BLANK = 1'b0,
    DWELL = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] shown_q, shown_d;
  logic [4*DIGITS-1:0] pval_q, pval_d;
  logic                pend_q, pend_d;
  logic                ready_q, ready_d;
  logic                fdone_q, fdone_d;
  logic [6:0]          disp_q, disp_d;
  logic [DIGITS-1:0]   anode_q, anode_d;

  logic                commit;
  logic                accept;
  logic                lit;
  logic                sel_lz;
  logic [3:0]          nib;
`ifdef LEADING_ZERO_BLANK_EN
  logic                zacc;
`endif

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      BLANK: begin
        if (cnt_q == BL_LAST) begin
          state_d = DWELL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DWELL: begin
        if (cnt_q == DW_LAST) begin
          cnt_d   = '0;
          idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
          state_d = (BLANK_CYCLES == 0) ? DWELL : BLANK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Load handshake; commit only on the edge that ends the frame,
  // so the new value first appears on digit 0 of the next frame.
  always_comb begin
    commit  = fdone_q && pend_q;
    accept  = LOAD && ready_q;
    shown_d = commit ? pval_q : shown_q;
    pval_d  = accept ? VALUE_IN : pval_q;
    pend_d  = commit ? 1'b0 : (accept ? 1'b1 : pend_q);
    ready_d = !pend_d;
  end

  // Outputs are registered from next-state so they line up with it.
  always_comb begin
    nib     = 4'h0;
    sel_lz  = 1'b0;
    anode_d = '1;
`ifdef LEADING_ZERO_BLANK_EN
    zacc = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zacc = zacc & (shown_d[4*k +: 4] == 4'h0);
      if (idx_d == IW'(k)) begin
        nib    = shown_d[4*k +: 4];
        sel_lz = zacc && (k != 0);
      end
    end
`else
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_d == IW'(k)) begin
        nib = shown_d[4*k +: 4];
      end
    end
`endif
    lit = (state_d == DWELL) && !sel_lz;
    for (int k = 0; k < DIGITS; k++) begin
      anode_d[k] = !(lit && (idx_d == IW'(k)));
    end
    disp_d  = lit ? seg(nib) : 7'h7F;
    fdone_d = (state_d == DWELL) && (cnt_d == DW_LAST) &&
              (idx_d == LAST_IDX);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      shown_q <= '0;
      pval_q  <= '0;
      pend_q  <= 1'b0;
      ready_q <= 1'b1;
      fdone_q <= 1'b0;
      disp_q  <= 7'h7F;
      anode_q <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shown_q <= shown_d;
      pval_q  <= pval_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
      fdone_q <= fdone_d;
      disp_q  <= disp_d;
      anode_q <= anode_d;
    end
  end

  assign READY      = ready_q;
  assign FRAME_DONE = fdone_q;
  assign DISPLAY    = disp_q;
  assign ANODE      = anode_q;

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Bench for seven_seg_scan_controller: 4 digits, dwell 4, blank 1 and blank 0.
// Random loads checked each cycle against a frame-position reference model.
module tb_seven_seg_scan_controller;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        LOAD = 1'b0;
  logic [15:0] VALUE_IN = '0;

  logic        ra, fa, rb, fb;
  logic [6:0]  da, db;
  logic [3:0]  aa, ab;

  always #5 CLK = ~CLK;

  seven_seg_scan_controller #(
    .DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(1)
  ) u_a (
    .CLK(CLK), .RESET(RESET), .VALUE_IN(VALUE_IN), .LOAD(LOAD),
    .READY(ra), .DISPLAY(da), .ANODE(aa), .FRAME_DONE(fa)
  );

  seven_seg_scan_controller #(
    .DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(0)
  ) u_b (
    .CLK(CLK), .RESET(RESET), .VALUE_IN(VALUE_IN), .LOAD(LOAD),
    .READY(rb), .DISPLAY(db), .ANODE(ab), .FRAME_DONE(fb)
  );

  int ncmp = 0;
  int nerr = 0;
  int c = 0;

  logic [15:0] sh[2];
  logic [15:0] pv[2];
  bit          pf[2];

  logic [6:0] glyph[16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Where in the frame cycle cy (counted from reset release) falls.
  function automatic void slot(input int inst, input int cy,
                               output bit lit, output int dig,
                               output bit fd);
    int p;
    if (inst == 0) begin
      p   = cy % 20;
      dig = p / 5;
      lit = (p % 5) != 0;
      fd  = (p == 19);
    end else if (cy == 0) begin
      dig = 0;
      lit = 1'b0;
      fd  = 1'b0;
    end else begin
      p   = (cy - 1) % 16;
      dig = p / 4;
      lit = 1'b1;
      fd  = (p == 15);
    end
  endfunction

  task automatic model_reset();
    c = 0;
    for (int i = 0; i < 2; i++) begin
      sh[i] = '0;
      pv[i] = '0;
      pf[i] = 1'b0;
    end
  endtask

  task automatic check_all();
    bit         lit, fd;
    int         dig;
    logic [3:0] nb, one, ea;
    logic [6:0] ed;
    for (int i = 0; i < 2; i++) begin
      slot(i, c, lit, dig, fd);
      nb = 4'(sh[i] >> (4 * dig));
`ifdef LEADING_ZERO_BLANK_EN
      if (dig > 0 && (sh[i] >> (4 * dig)) == 16'h0) lit = 1'b0;
`endif
      one = 4'b0001 << dig;
      ea  = lit ? ~one : 4'hF;
      ed  = lit ? glyph[nb] : 7'h7F;
      chk($sformatf("anode%0d c%0d", i, c),
          32'(i == 0 ? aa : ab), 32'(ea));
      chk($sformatf("display%0d c%0d", i, c),
          32'(i == 0 ? da : db), 32'(ed));
      chk($sformatf("ready%0d c%0d", i, c),
          32'(i == 0 ? ra : rb), 32'(!pf[i]));
      chk($sformatf("fdone%0d c%0d", i, c),
          32'(i == 0 ? fa : fb), 32'(fd));
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " anodeA"}, 32'(aa), 32'hF);
    chk({tag, " dispA"}, 32'(da), 32'h7F);
    chk({tag, " readyA"}, 32'(ra), 32'h1);
    chk({tag, " fdoneA"}, 32'(fa), 32'h0);
    chk({tag, " anodeB"}, 32'(ab), 32'hF);
    chk({tag, " dispB"}, 32'(db), 32'h7F);
    chk({tag, " readyB"}, 32'(rb), 32'h1);
    chk({tag, " fdoneB"}, 32'(fb), 32'h0);
  endtask

  // One clock: check the current cycle, drive inputs, advance model.
  task automatic step(input bit ld, input logic [15:0] v);
    bit lit, fd, acc;
    int dig;
    check_all();
    LOAD     = ld;
    VALUE_IN = v;
    @(posedge CLK);
    for (int i = 0; i < 2; i++) begin
      slot(i, c, lit, dig, fd);
      acc = ld && !pf[i];
      if (fd && pf[i]) begin
        sh[i] = pv[i];
        pf[i] = 1'b0;
      end else if (acc) begin
        pv[i] = v;
        pf[i] = 1'b1;
      end
    end
    c++;
    @(negedge CLK);
  endtask

  initial begin
    bit lit, fd, found;
    int dig;

    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    chk_reset_outs("por");
    RESET = 1'b0;
    model_reset();

    repeat (25) step(1'b0, 16'h0);
    step(1'b1, 16'hF8A1);
    step(1'b1, 16'h1234);
    repeat (45) step(1'b0, 16'($urandom));

    found = 1'b0;
    for (int g = 0; g < 40; g++) begin
      slot(0, c, lit, dig, fd);
      if (fd && !pf[0]) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 16'h0);
    end
    chk("fd_load_window", 32'(found), 32'h1);
    step(1'b1, 16'hABCD);
    repeat (45) step(1'b0, 16'h0);

    repeat (300) step($urandom_range(0, 5) == 0, 16'($urandom));

    found = 1'b0;
    for (int g = 0; g < 80; g++) begin
      if ((c % 20) == 6 && !pf[0]) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 16'h0);
    end
    chk("pend_window", 32'(found), 32'h1);
    step(1'b1, 16'h7E35);
    while ((c % 20) != 12) step(1'b0, 16'h0);
    check_all();
    #2 RESET = 1'b1;
    #1 chk_reset_outs("async");
    @(posedge CLK);
    #1 chk_reset_outs("held");
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    repeat (45) step(1'b0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
